dma_warp_scheduler: RTL and testbench

- Shares one DMA engine among all warps of a core.
- Accepts at most one DMA request per warp and holds each requesting warp stalled until its transfer completes.
- Picks among pending warps round-robin, issues one transfer at a time to the engine, and releases the warp when the engine responds.
- Its stall mask feeds the warp scheduler's ready-warp computation, where it is inverted and ANDed with the active and not-stalled masks.

---
 rtl/dma_warp_scheduler.sv | 178 +++++++++++++++++
 tb/tb_dma_warp_scheduler.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_warp_scheduler.sv
// DMA warp scheduler: shares one DMA engine among the warps of a core.
// Each warp may hold one outstanding request; requesting warps stay stalled
// until their transfer completes. Pending warps are served round-robin and
// only one transfer is in flight at a time.
module dma_warp_scheduler #(
    parameter int NUM_WARPS  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    localparam int NW_WIDTH  = $clog2(NUM_WARPS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [NW_WIDTH-1:0]   req_wid,
    input  logic [ADDR_WIDTH-1:0] req_src,
    input  logic [ADDR_WIDTH-1:0] req_dst,
    input  logic [LEN_WIDTH-1:0]  req_len,
    output logic                  dma_req_valid,
    input  logic                  dma_req_ready,
    output logic [ADDR_WIDTH-1:0] dma_req_src,
    output logic [ADDR_WIDTH-1:0] dma_req_dst,
    output logic [LEN_WIDTH-1:0]  dma_req_len,
    output logic [NW_WIDTH-1:0]   dma_req_tag,
    input  logic                  dma_rsp_valid,
    input  logic [NW_WIDTH-1:0]   dma_rsp_tag,
    output logic [NUM_WARPS-1:0]  dma_warp_stall,
    output logic                  tag_err,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int NW_POW = 1 << NW_WIDTH;
    localparam logic [NW_WIDTH-1:0] LAST_WARP = NW_WIDTH'(NUM_WARPS - 1);

    state_t                state;
    state_t                state_next;
    logic [NUM_WARPS-1:0]  pending;
    logic [NUM_WARPS-1:0]  inflight;
    logic [ADDR_WIDTH-1:0] tbl_src [NUM_WARPS];
    logic [ADDR_WIDTH-1:0] tbl_dst [NUM_WARPS];
    logic [LEN_WIDTH-1:0]  tbl_len [NUM_WARPS];
    logic [NW_WIDTH-1:0]   rr_ptr;
    logic [NW_WIDTH-1:0]   grant;
    logic                  grant_vld;
    logic                  do_grant;
    logic                  rsp_match;
    logic                  accept;
    logic [NW_POW-1:0]     stall_ext;

    // Stall mask is built purely from registered state, so readiness never
    // depends on this cycle's request or response inputs.
    assign dma_warp_stall = pending | inflight;
    // Warp ids beyond NUM_WARPS (non-power-of-two configs) read as stalled.
    assign stall_ext      = ~NW_POW'(~dma_warp_stall);
    assign req_ready      = ~stall_ext[req_wid];
    assign accept         = req_valid && req_ready;
    assign dma_req_valid  = (state == ISSUE);
    assign busy           = (pending != '0) || (state != IDLE);

    // Round-robin search: first pending warp at or after rr_ptr, wrapping.
    always_comb begin
        int                  idx;
        logic [NW_WIDTH-1:0] cand;
        grant     = '0;
        grant_vld = 1'b0;
        idx       = 0;
        cand      = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_WARPS) begin
                idx = idx - NUM_WARPS;
            end
            cand = NW_WIDTH'(idx);
            if (!grant_vld && pending[cand]) begin
                grant_vld = 1'b1;
                grant     = cand;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: grant in IDLE, hold request in ISSUE, await tag in WAIT.
    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        rsp_match  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    do_grant   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (dma_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // dma_req_tag still holds the in-flight warp id.
                if (dma_rsp_valid && (dma_rsp_tag == dma_req_tag)) begin
                    rsp_match  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Per-warp control: pending/inflight bits, round-robin pointer, sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= '0;
            inflight <= '0;
            rr_ptr   <= '0;
            tag_err  <= 1'b0;
        end else begin
            if (do_grant) begin
                pending[grant]  <= 1'b0;
                inflight[grant] <= 1'b1;
                rr_ptr          <= (grant == LAST_WARP) ? '0 : grant + 1'b1;
            end
            // A warp being accepted is never pending, so it cannot collide
            // with the grant clear above.
            if (accept && (req_len != '0)) begin
                pending[req_wid] <= 1'b1;
            end
            if (rsp_match) begin
                inflight <= '0;
            end
            if (dma_rsp_valid && !rsp_match) begin
                tag_err <= 1'b1;
            end
        end
    end

    // Request table: one {src,dst,len} entry per warp; zero-length requests
    // are acknowledged without touching it.
    always_ff @(posedge clk) begin
        if (accept && (req_len != '0)) begin
            tbl_src[req_wid] <= req_src;
            tbl_dst[req_wid] <= req_dst;
            tbl_len[req_wid] <= req_len;
        end
    end

    // Engine request registers: loaded on grant, held stable through ISSUE.
    always_ff @(posedge clk) begin
        if (reset) begin
            dma_req_src <= '0;
            dma_req_dst <= '0;
            dma_req_len <= '0;
            dma_req_tag <= '0;
        end else if (do_grant) begin
            dma_req_src <= tbl_src[grant];
            dma_req_dst <= tbl_dst[grant];
            dma_req_len <= tbl_len[grant];
            dma_req_tag <= grant;
        end
    end

endmodule

// File: tb/tb_dma_warp_scheduler.sv
// Testbench for dma_warp_scheduler: directed scenarios plus random traffic,
// checked against a transaction-level reference model and an issue scoreboard.
module tb_dma_warp_scheduler;

    localparam int NW = 4;
    localparam int AW = 32;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_wid;
    logic [AW-1:0] req_src;
    logic [AW-1:0] req_dst;
    logic [LW-1:0] req_len;
    logic          dma_req_valid;
    logic          dma_req_ready;
    logic [AW-1:0] dma_req_src;
    logic [AW-1:0] dma_req_dst;
    logic [LW-1:0] dma_req_len;
    logic [1:0]    dma_req_tag;
    logic          dma_rsp_valid;
    logic [1:0]    dma_rsp_tag;
    logic [NW-1:0] dma_warp_stall;
    logic          tag_err;
    logic          busy;

    always #5 clk = ~clk;

    dma_warp_scheduler #(.NUM_WARPS(NW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wid(req_wid),
        .req_src(req_src), .req_dst(req_dst), .req_len(req_len),
        .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
        .dma_req_src(dma_req_src), .dma_req_dst(dma_req_dst),
        .dma_req_len(dma_req_len), .dma_req_tag(dma_req_tag),
        .dma_rsp_valid(dma_rsp_valid), .dma_rsp_tag(dma_rsp_tag),
        .dma_warp_stall(dma_warp_stall), .tag_err(tag_err), .busy(busy)
    );

    typedef struct {
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [LW-1:0] len;
        logic [1:0]    tag;
    } xfer_t;

    xfer_t exp_q[$];
    int    issued_log[$];
    int    hs_lat[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    vcyc  = 0;

    // Reference model: a table of waiting requests, a rotating priority
    // pointer, and which phase the single shared engine slot is in
    // (0 = free, 1 = offered to engine, 2 = engine working on m_cur).
    bit            m_pend [NW];
    logic [AW-1:0] m_src  [NW];
    logic [AW-1:0] m_dst  [NW];
    logic [LW-1:0] m_len  [NW];
    int            m_ptr, m_phase, m_cur;
    bit            m_err, m_acc;

    // Engine emulation knobs.
    bit rand_mode;
    bit rsp_en;
    int bp_cnt;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [NW-1:0] m_stall();
        logic [NW-1:0] s;
        for (int w = 0; w < NW; w++) s[w] = m_pend[w];
        if (m_phase != 0) s[m_cur] = 1'b1;
        return s;
    endfunction

    function automatic bit m_any_pend();
        bit a = 0;
        for (int w = 0; w < NW; w++) a |= m_pend[w];
        return a;
    endfunction

    task automatic model_clear();
        for (int w = 0; w < NW; w++) m_pend[w] = 0;
        m_ptr = 0; m_phase = 0; m_cur = 0; m_err = 0; m_acc = 0;
        exp_q.delete();
    endtask

    task automatic drive_engine();
        dma_rsp_valid = 1'b0;
        dma_rsp_tag   = 2'd0;
        if (bp_cnt > 0 && m_phase == 1) begin
            dma_req_ready = 1'b0;
            bp_cnt--;
        end else begin
            dma_req_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (rsp_en && m_phase == 2 && (!rand_mode || $urandom_range(0, 2) == 0)) begin
            dma_rsp_valid = 1'b1;
            dma_rsp_tag   = 2'(m_cur);
        end
    endtask

    // One clock: compare DUT against the model mid-cycle, advance the model
    // over the coming edge, then drive the engine side for the next cycle.
    task automatic step();
        logic [NW-1:0] st;
        bit            rdy;
        int            ph, g, w;
        @(negedge clk);
        st  = m_stall();
        rdy = !st[req_wid];
        check("req_ready", req_ready, rdy);
        check("dma_req_valid", dma_req_valid, m_phase == 1);
        check("stall", dma_warp_stall, st);
        check("busy", busy, m_any_pend() || m_phase != 0);
        check("tag_err", tag_err, m_err);
        if (reset) begin
            model_clear();
        end else begin
            ph    = m_phase;
            m_acc = req_valid && rdy;
            if (dma_rsp_valid && !(ph == 2 && int'(dma_rsp_tag) == m_cur)) m_err = 1;
            if (ph == 0) begin
                g = -1;
                for (int k = 0; k < NW; k++) begin
                    w = (m_ptr + k) % NW;
                    if (g < 0 && m_pend[w]) g = w;
                end
                if (g >= 0) begin
                    exp_q.push_back('{src: m_src[g], dst: m_dst[g], len: m_len[g], tag: 2'(g)});
                    m_pend[g] = 0;
                    m_cur     = g;
                    m_ptr     = (g + 1) % NW;
                    m_phase   = 1;
                end
            end else if (ph == 1 && dma_req_ready) begin
                m_phase = 2;
            end else if (ph == 2 && dma_rsp_valid && int'(dma_rsp_tag) == m_cur) begin
                m_phase = 0;
            end
            if (m_acc && req_len != 0) begin
                m_pend[req_wid] = 1;
                m_src[req_wid]  = req_src;
                m_dst[req_wid]  = req_dst;
                m_len[req_wid]  = req_len;
            end
        end
        @(posedge clk);
        #1;
        drive_engine();
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic set_req(bit v, int wid, logic [AW-1:0] s, logic [AW-1:0] d, logic [LW-1:0] l);
        req_valid = v;
        req_wid   = 2'(wid);
        req_src   = s;
        req_dst   = d;
        req_len   = l;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        bp_cnt = 0;
        step();
        reset  = 1'b0;
    endtask

    // Scoreboard monitor: every cycle the engine sees a request, its fields
    // must match the oldest expected issue; it retires on the handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                vcyc = 0;
            end else if (dma_req_valid) begin
                vcyc++;
                if (exp_q.size() == 0) begin
                    check("issue_expected", exp_q.size() != 0, 1);
                end else begin
                    check("issue_src", dma_req_src, exp_q[0].src);
                    check("issue_dst", dma_req_dst, exp_q[0].dst);
                    check("issue_len", dma_req_len, exp_q[0].len);
                    check("issue_tag", dma_req_tag, exp_q[0].tag);
                    if (dma_req_ready) begin
                        issued_log.push_back(int'(dma_req_tag));
                        hs_lat.push_back(vcyc);
                        vcyc = 0;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int  exp_order[4];
        int  n_before;
        bit  got;
        logic [NW-1:0] st;

        exp_order = '{0, 1, 3, 0};
        rand_mode = 0; rsp_en = 1; bp_cnt = 0;
        set_req(0, 0, '0, '0, '0);
        dma_req_ready = 1'b1; dma_rsp_valid = 1'b0; dma_rsp_tag = 2'd0;
        model_clear();
        reset = 1'b1;
        @(posedge clk);
        #1;
        do_reset();
        check("rst_src", dma_req_src, 0);
        check("rst_dst", dma_req_dst, 0);
        check("rst_len", dma_req_len, 0);
        check("rst_tag", dma_req_tag, 0);

        // Single request from warp 2.
        set_req(1, 2, 32'h1000, 32'h2000, 16'd64);
        step();
        set_req(0, 0, '0, '0, '0);
        check("t1_stall_next", dma_warp_stall, 4'b0100);
        step();
        check("t1_valid", dma_req_valid, 1);
        check("t1_tag", dma_req_tag, 2);
        run(4);
        check("t1_stall_clear", dma_warp_stall, 0);
        check("t1_busy_clear", busy, 0);

        // Duplicate request from warp 1 while its first is outstanding.
        rsp_en = 0;
        set_req(1, 1, 32'h3000, 32'h4000, 16'd8);
        step();
        set_req(1, 1, 32'h5000, 32'h6000, 16'd16);
        run(4);
        check("t2_ready_blocked", req_ready, 0);
        rsp_en = 1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            got = m_acc;
        end
        check("t2_reaccept", got, 1);
        set_req(0, 0, '0, '0, '0);
        run(8);

        // Round-robin: warps 0,1,3 back to back, then warp 0 again.
        issued_log.delete();
        set_req(1, 0, 32'h100, 32'h200, 16'd4);  step();
        set_req(1, 1, 32'h110, 32'h210, 16'd5);  step();
        set_req(1, 3, 32'h130, 32'h230, 16'd7);  step();
        set_req(0, 0, '0, '0, '0);
        st = m_stall();
        for (int i = 0; i < 20 && st[0]; i++) begin
            step();
            st = m_stall();
        end
        set_req(1, 0, 32'h140, 32'h240, 16'd9);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            got = m_acc;
        end
        set_req(0, 0, '0, '0, '0);
        run(20);
        check("t3_count", issued_log.size(), 4);
        if (issued_log.size() == 4) begin
            for (int i = 0; i < 4; i++) check("t3_order", issued_log[i], exp_order[i]);
        end

        // Engine backpressure: ready low for 5 offered cycles.
        bp_cnt = 5;
        set_req(1, 2, 32'hA0A0, 32'hB0B0, 16'h123);
        step();
        set_req(0, 0, '0, '0, '0);
        run(12);
        check("t4_hs_seen", hs_lat.size() != 0, 1);
        if (hs_lat.size() != 0) check("t4_handshake_cycle", hs_lat[$], 6);

        // Zero-length request: acknowledged, never issued.
        n_before = issued_log.size();
        set_req(1, 3, 32'hDEAD, 32'hBEEF, 16'd0);
        step();
        set_req(0, 0, '0, '0, '0);
        check("t5_stall", dma_warp_stall, 0);
        run(5);
        check("t5_no_issue", issued_log.size(), n_before);

        // Wrong-tag response while warp 0 is in flight, then reset in WAIT.
        rsp_en = 0;
        set_req(1, 0, 32'h7000, 32'h8000, 16'd32);
        step();
        set_req(0, 0, '0, '0, '0);
        for (int i = 0; i < 20 && m_phase != 2; i++) step();
        dma_rsp_valid = 1'b1;
        dma_rsp_tag   = 2'd1;
        step();
        check("t6_tag_err", tag_err, 1);
        check("t6_warp0_stalled", dma_warp_stall[0], 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_rst_valid", dma_req_valid, 0);
        check("t6_rst_stall", dma_warp_stall, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_err", tag_err, 0);
        check("t6_rst_tag", dma_req_tag, 0);
        check("t6_rst_src", dma_req_src, 0);
        check("t6_rst_len", dma_req_len, 0);
        dma_rsp_valid = 1'b1;
        dma_rsp_tag   = 2'd0;
        step();
        check("t6_late_rsp_err", tag_err, 1);
        do_reset();
        rsp_en = 1;

        // Random traffic.
        rand_mode = 1;
        for (int c = 0; c < 1500; c++) begin
            set_req($urandom_range(0, 1), $urandom_range(0, NW - 1), $urandom, $urandom,
                    ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535)));
            step();
        end
        rand_mode = 0;
        set_req(0, 0, '0, '0, '0);
        for (int i = 0; i < 200 && (m_phase != 0 || m_any_pend()); i++) step();
        check("drain_idle", (m_phase != 0 || m_any_pend()), 0);
        run(3);
        check("drain_queue", exp_q.size(), 0);
        check("drain_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
